// File: rtl/lcd_pkg.sv
// Shared constants, types and helpers for the HD44780 bus capture block.
package lcd_pkg;

    localparam logic [7:0] CMD_CLR    = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_ENTRY  = 8'h04;
    localparam logic [7:0] CMD_DISP   = 8'h08;
    localparam logic [7:0] CMD_DDRAM  = 8'h80;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam int         NUM_CELLS  = 32;
    localparam logic [6:0] LINE2_BASE = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_CLEAR
    } ctrl_state_t;

    typedef struct packed {
        logic       rw;
        logic       rs;
        logic [7:0] data;
    } bus_word_t;

    // Maps a DDRAM address to {hit, cell}; line 2 starts at LINE2_BASE.
    function automatic logic [5:0] ddram_to_cell(input logic [6:0] addr);
        if (addr < 7'h10)
            return {1'b1, addr[4:0]};
        else if (addr[6:4] == LINE2_BASE[6:4])
            return {1'b1, 1'b1, addr[3:0]};
        else
            return 6'b0;
    endfunction

endpackage

// File: rtl/lcd_capture_if.sv
// HD44780 pin bundle; the capture block only ever observes it.
interface lcd_capture_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    modport master (output LCD_DATA, output LCD_RS, output LCD_RW, output LCD_EN);
    modport slave  (input  LCD_DATA, input  LCD_RS, input  LCD_RW, input  LCD_EN);
endinterface

// File: rtl/lcd_char_ram.sv
// 32x8 character store: one write port, one registered read port (read-before-write).
module lcd_char_ram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [NUM_CELLS];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (srst)
            rdata_reg <= CHAR_SPACE;
        else
            rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/lcd_capture.sv
// Snoops an HD44780 write bus and mirrors the 2x16 character display into local RAM.
module lcd_capture
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLOCK_50,
    input  logic          RST,
    lcd_capture_if.slave  lcd,
    input  logic [4:0]    rd_addr,
    output logic [7:0]    rd_char,
    output logic [4:0]    cursor,
    output logic          disp_on,
    output logic          busy,
    output logic          cmd_err,
    output logic          overrun
);

    logic [10:0] pin_word;
    assign pin_word = {lcd.LCD_EN, lcd.LCD_RW, lcd.LCD_RS, lcd.LCD_DATA};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [10:0] q;
            if (gi == 0) begin : g_in
                always_ff @(posedge CLOCK_50) begin
                    if (RST) q <= '0;
                    else     q <= pin_word;
                end
            end else begin : g_chain
                always_ff @(posedge CLOCK_50) begin
                    if (RST) q <= '0;
                    else     q <= g_sync[gi-1].q;
                end
            end
        end
    endgenerate

    logic [10:0] last_stage;
    logic        last_en;
    bus_word_t   last_word;
    assign last_stage = g_sync[SYNC_STAGES-1].q;
    assign last_en    = last_stage[10];
    assign last_word  = bus_word_t'(last_stage[9:0]);

    ctrl_state_t state_reg;
    bus_word_t   cap_reg;
    logic        cap_valid_reg;
    logic        en_d_reg;
    logic [4:0]  clr_idx_reg;
    logic [4:0]  cursor_reg;
    logic        id_reg;
    logic        disp_on_reg;
    logic        busy_reg;
    logic        cmd_err_reg;
    logic        overrun_reg;

    logic        fall;
    logic        wr_strobe;
    logic [5:0]  ddram_hit;
    assign fall      = en_d_reg & ~last_en;
    assign wr_strobe = cap_valid_reg & ~cap_reg.rw;
    assign ddram_hit = ddram_to_cell(cap_reg.data[6:0]);

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_reg     <= ST_START;
            cap_reg       <= '0;
            cap_valid_reg <= 1'b0;
            en_d_reg      <= 1'b0;
            clr_idx_reg   <= '0;
            cursor_reg    <= '0;
            id_reg        <= 1'b1;
            disp_on_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            cmd_err_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            en_d_reg      <= last_en;
            cap_valid_reg <= fall;
            if (fall)
                cap_reg <= last_word;
            cmd_err_reg <= 1'b0;

            case (state_reg)
                ST_START: begin
                    state_reg   <= ST_CLEAR;
                    busy_reg    <= 1'b1;
                    clr_idx_reg <= '0;
                end
                ST_CLEAR: begin
                    clr_idx_reg <= clr_idx_reg + 5'd1;
                    if (clr_idx_reg == 5'(NUM_CELLS - 1)) begin
                        state_reg  <= ST_IDLE;
                        busy_reg   <= 1'b0;
                        cursor_reg <= '0;
                        id_reg     <= 1'b1;
                    end
                end
                default: ;
            endcase

            // A pending clear counts as busy so no strobe can slip into its first cycle.
            if (wr_strobe) begin
                if (state_reg != ST_IDLE) begin
                    overrun_reg <= 1'b1;
                end else if (cap_reg.rs) begin
                    cursor_reg <= id_reg ? cursor_reg + 5'd1 : cursor_reg - 5'd1;
                end else if (|(cap_reg.data & CMD_DDRAM)) begin
                    if (ddram_hit[5]) cursor_reg  <= ddram_hit[4:0];
                    else              cmd_err_reg <= 1'b1;
                end else if (|cap_reg.data[6:4]) begin
                end else if (|(cap_reg.data & CMD_DISP)) begin
                    disp_on_reg <= cap_reg.data[2];
                end else if (|(cap_reg.data & CMD_ENTRY)) begin
                    id_reg <= cap_reg.data[1];
                end else if (|(cap_reg.data & CMD_HOME)) begin
                    cursor_reg <= '0;
                end else if (|(cap_reg.data & CMD_CLR)) begin
                    state_reg   <= ST_CLEAR;
                    busy_reg    <= 1'b1;
                    clr_idx_reg <= '0;
                end
            end
        end
    end

    logic       ram_we;
    logic [4:0] ram_waddr;
    logic [7:0] ram_wdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cursor_reg;
        ram_wdata = cap_reg.data;
        if (state_reg == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx_reg;
            ram_wdata = CHAR_SPACE;
        end else if (state_reg == ST_IDLE && wr_strobe && cap_reg.rs) begin
            ram_we = 1'b1;
        end
    end

    lcd_char_ram u_ram (
        .clk   (CLOCK_50),
        .srst  (RST),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_char)
    );

    assign cursor  = cursor_reg;
    assign disp_on = disp_on_reg;
    assign busy    = busy_reg;
    assign cmd_err = cmd_err_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_lcd_capture.sv
// Directed plus randomised HD44780 bus traffic checked against a display-level model.
module tb_lcd_capture;

    logic       CLOCK_50 = 1'b0;
    logic       RST      = 1'b1;
    logic [4:0] rd_addr  = '0;
    logic [7:0] rd_char;
    logic [4:0] cursor;
    logic       disp_on, busy, cmd_err, overrun;

    lcd_capture_if bus ();

    lcd_capture #(.SYNC_STAGES(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .lcd      (bus),
        .rd_addr  (rd_addr),
        .rd_char  (rd_char),
        .cursor   (cursor),
        .disp_on  (disp_on),
        .busy     (busy),
        .cmd_err  (cmd_err),
        .overrun  (overrun)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int vectors     = 0;
    int miscompares = 0;

    // Display-level reference model
    int cells_m [32];
    int cur_m, id_m, disp_m, ovr_m, err_m;
    int err_seen = 0;

    always @(posedge CLOCK_50) if (cmd_err === 1'b1) err_seen <= err_seen + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) cells_m[i] = 32;
        cur_m = 0; id_m = 1; disp_m = 0; ovr_m = 0;
    endfunction

    function automatic void model_strobe(input bit rs, input bit rw, input int d, input bit in_busy);
        int a;
        if (rw) return;
        if (in_busy) begin ovr_m = 1; return; end
        if (rs) begin
            cells_m[cur_m] = d;
            cur_m = id_m ? (cur_m + 1) % 32 : (cur_m + 31) % 32;
        end else if (d >= 128) begin
            a = d - 128;
            if (a < 16)                cur_m = a;
            else if (a >= 64 && a < 80) cur_m = 16 + (a - 64);
            else                        err_m++;
        end else if (d >= 16) begin
        end else if (d >= 8) begin
            disp_m = (d / 4) % 2;
        end else if (d >= 4) begin
            id_m = (d / 2) % 2;
        end else if (d >= 2) begin
            cur_m = 0;
        end else if (d == 1) begin
            for (int i = 0; i < 32; i++) cells_m[i] = 32;
            cur_m = 0; id_m = 1;
        end
    endfunction

    task automatic strobe(input bit rs, input bit rw, input int d, input int post, input bit in_busy);
        @(negedge CLOCK_50);
        bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_DATA = d[7:0]; bus.LCD_EN = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        bus.LCD_EN = 1'b0;
        repeat (post) @(negedge CLOCK_50);
        model_strobe(rs, rw, d, in_busy);
        $display("tx rs=%0d rw=%0d data=%02h cursor=%0d", rs, rw, d[7:0], cursor);
    endtask

    task automatic check_state(input string tag);
        @(negedge CLOCK_50);
        chk({tag, ".cursor"},  32'(cursor),  32'(cur_m));
        chk({tag, ".disp_on"}, 32'(disp_on), 32'(disp_m));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ovr_m));
        chk({tag, ".cmd_err"}, 32'(err_seen), 32'(err_m));
    endtask

    task automatic check_cells(input string tag);
        for (int a = 0; a < 32; a++) begin
            @(negedge CLOCK_50);
            rd_addr = 5'(a);
            @(posedge CLOCK_50);
            #1;
            chk($sformatf("%s.cell%0d", tag, a), 32'(rd_char), 32'(cells_m[a]));
        end
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (busy === 1'b1) n++;
            else if (n > 0) break;
        end
    endtask

    int n;
    int kind, d;

    initial begin
        bus.LCD_DATA = '0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_EN = 1'b0;
        err_m = 0;
        repeat (4) @(negedge CLOCK_50);
        chk("rst.rd_char", 32'(rd_char), 32'h20);
        chk("rst.cursor",  32'(cursor),  32'd0);
        chk("rst.disp_on", 32'(disp_on), 32'd0);
        chk("rst.cmd_err", 32'(cmd_err), 32'd0);
        chk("rst.overrun", 32'(overrun), 32'd0);
        RST = 1'b0;
        model_reset();
        busy_len(n);
        chk("init.busy_len", 32'(n), 32'd32);
        check_cells("init");
        check_state("init");

        // Function set, display on, entry increment, home address, "HI"
        strobe(0, 0, 'h38, 8, 0); strobe(0, 0, 'h0C, 8, 0); strobe(0, 0, 'h06, 8, 0);
        strobe(0, 0, 'h80, 8, 0); strobe(1, 0, 'h48, 8, 0); strobe(1, 0, 'h49, 8, 0);
        check_state("hi");
        check_cells("hi");

        strobe(0, 0, 'hCF, 8, 0); strobe(1, 0, 'h41, 8, 0); strobe(1, 0, 'h42, 8, 0);
        check_state("wrap_inc");
        check_cells("wrap_inc");

        strobe(0, 0, 'h04, 8, 0); strobe(0, 0, 'h80, 8, 0); strobe(1, 0, 'h5A, 8, 0);
        check_state("wrap_dec");
        check_cells("wrap_dec");

        // Write latency from pin-level EN fall, read port parked on the target cell
        @(negedge CLOCK_50);
        rd_addr = 5'(cur_m);
        bus.LCD_RS = 1'b1; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h33; bus.LCD_EN = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        bus.LCD_EN = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        #1;
        chk("latency.rd_char", 32'(rd_char), 32'h33);
        model_strobe(1, 0, 'h33, 0);
        $display("tx rs=1 rw=0 data=33 cursor=%0d", cursor);
        check_state("latency");

        strobe(0, 0, 'h95, 8, 0);
        check_state("bad_ddram");

        strobe(1, 1, 'h41, 8, 0);
        check_state("read_strobe");
        check_cells("read_strobe");

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: strobe(1, 0, $urandom_range(32, 126), 8, 0);
                4: begin
                    case ($urandom_range(0, 2))
                        0: d = 'h80 + $urandom_range(0, 15);
                        1: d = 'hC0 + $urandom_range(0, 15);
                        default: d = 'h80 + $urandom_range(0, 127);
                    endcase
                    strobe(0, 0, d, 8, 0);
                end
                5: strobe(0, 0, 'h04 + $urandom_range(0, 3), 8, 0);
                6: strobe(0, 0, 'h08 + $urandom_range(0, 7), 8, 0);
                7: strobe(0, 0, ($urandom_range(0, 1) != 0) ? 'h02 + $urandom_range(0, 1)
                                                              : 'h10 + $urandom_range(0, 111), 8, 0);
                8: strobe($urandom_range(0, 1) != 0, 1, $urandom_range(0, 255), 8, 0);
                default: strobe(0, 0, 'h01, 40, 0);
            endcase
            check_state($sformatf("rand%0d", it));
            if (it % 20 == 19) check_cells($sformatf("rand%0d", it));
        end

        // Clear immediately followed by a data strobe that lands inside the clear
        strobe(0, 0, 'h01, 0, 0);
        strobe(1, 0, 'h41, 40, 1);
        check_state("overrun");
        check_cells("overrun");

        // Reset in the middle of the start-up clear
        strobe(1, 0, 'h55, 8, 0);
        @(negedge CLOCK_50); RST = 1'b1;
        repeat (2) @(negedge CLOCK_50); RST = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        #1;
        chk("midclr.busy", 32'(busy), 32'd1);
        @(negedge CLOCK_50); RST = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("midclr.overrun_rst", 32'(overrun), 32'd0);
        RST = 1'b0;
        model_reset();
        busy_len(n);
        chk("midclr.busy_len", 32'(n), 32'd32);
        check_state("midclr");
        check_cells("midclr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_capture.md
LCD_CAPTURE -- requirements
Module: lcd_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on each LCD bus input.
REQ-002 Port CLOCK_50, input, 1: single system clock; all state changes on its rising edge.
REQ-003 Port RST, input, 1: synchronous, active-high reset.
REQ-004 Port LCD_DATA, input, 8: HD44780 data bus, observed only, never driven.
REQ-005 Port LCD_RS, input, 1: 0 = command, 1 = character data.
REQ-006 Port LCD_RW, input, 1: 0 = write, 1 = read.
REQ-007 Port LCD_EN, input, 1: bus strobe; the transfer is taken on its falling edge.
REQ-008 Port rd_addr, input, 5: character cell to read (0-15 line 1, 16-31 line 2).
REQ-009 Port rd_char, output, 8: contents of cell rd_addr, registered.
REQ-010 Port cursor, output, 5: current write cell index.
REQ-011 Port disp_on, output, 1: display-on bit from the last display-control command.
REQ-012 Port busy, output, 1: high while a clear sequence runs.
REQ-013 Port cmd_err, output, 1: one-cycle pulse for an unsupported DDRAM address.
REQ-014 Port overrun, output, 1: sticky flag set when a strobe arrives while busy.

Function
REQ-015 LCD_DATA, LCD_RS, LCD_RW and LCD_EN SHALL each pass through SYNC_STAGES flops; an EN falling edge is detected on the synchronised EN, comparing the last stage with one further flop.
REQ-016 On a detected falling edge, the synchronised DATA, RS and RW from the same stage SHALL be decoded in the next cycle.
REQ-017 With RW=1 the strobe SHALL be ignored, with no state change.
REQ-018 RS=1 SHALL write DATA into cell cursor, then step cursor by +1 (I/D=1) or -1 (I/D=0).
  - Cursor wraps 31->0 on increment and 0->31 on decrement.
REQ-019 RS=0 commands SHALL be decoded by highest set bit:
  - 0x01 clear: start the clear sequence.
  - 0x02/0x03 home: cursor=0.
  - 0x04-0x07 entry mode: latch I/D=DATA[1].
  - 0x08-0x0F display control: disp_on=DATA[2].
  - 0x10-0x7F: accept, no effect.
  - 0x80-0xFF set DDRAM address: A=DATA[6:0].
REQ-020 For set DDRAM address, A=0x00-0x0F SHALL set cursor=A, and A=0x40-0x4F SHALL set cursor=16+(A-0x40).
  - Any other A leaves cursor unchanged and pulses cmd_err for one cycle.
REQ-021 Clear sequence SHALL raise busy in the cycle after decode and write 0x20 to cells 0..31, one per cycle (32 cycles).
  - Then deassert busy and set cursor=0, I/D=1.
REQ-022 Any write-strobe (RW=0) detected while busy=1 SHALL be dropped and SHALL set overrun.
  - overrun clears only on RST.
REQ-023 A data write SHALL be visible on rd_char no later than SYNC_STAGES+3 cycles after the pin-level EN fall.
  - This holds when rd_addr points at the written cell.
REQ-024 rd_char SHALL equal the cell content at rd_addr sampled one cycle earlier (one-cycle read latency).
REQ-025 If a write and a read target the same cell in the same cycle, rd_char SHALL return the old value.

Reset
REQ-026 On RST:
  - cursor=0, I/D=1, disp_on=0, cmd_err=0, overrun=0, rd_char=0x20.
  - Synchroniser and edge flops cleared to 0.
REQ-027 On the cycle after RST deasserts, a clear sequence SHALL start, so busy=1 for 32 cycles and all cells read 0x20 afterwards.
REQ-028 RST asserted mid-clear or mid-decode SHALL abort the operation and restart per REQ-027.

Structure
REQ-029 A shared package lcd_pkg SHALL hold:
  - Command codes: CLR=0x01, HOME=0x02, ENTRY=0x04, DISP=0x08, DDRAM=0x80.
  - Constants: CHAR_SPACE=0x20, NUM_CELLS=32, LINE2_BASE=0x40.
REQ-030 Character storage SHALL be a sub-module lcd_char_ram: 32x8, one synchronous write port, one synchronous read port.

Verification
REQ-031 After RST release: busy high for exactly 32 cycles; rd_addr 0..31 all return 0x20; cursor=0.
REQ-032 Commands 0x38, 0x0C, 0x06, 0x80, then data 'H'(0x48), 'I'(0x49):
  - disp_on=1, cell0=0x48, cell1=0x49, cursor=2.
REQ-033 Commands 0xCF then data 0x41, 0x42 (increment mode):
  - cell31=0x41, cell0=0x42, cursor=1 (wrap).
REQ-034 Command 0x04, then 0x80, then data 0x5A:
  - cell0=0x5A, cursor=31.
REQ-035 Command 0x95: cmd_err pulses once, cursor unchanged.
  - Command 0x01 immediately followed by data 0x41 while busy: 0x41 dropped, overrun=1, all cells 0x20.
REQ-036 Strobe with RW=1, DATA=0x41, RS=1: no cell, cursor or flag change.
  - RST asserted at clear cycle 10: full 32-cycle clear restarts after release.
